puf_host_ctrl: RTL and testbench
================================

Name: puf_host_ctrl

Overview:
- Host-side initiator for the PUF challenge/response UART link.
- Serializes a 16-bit challenge onto `tx` as two 8N1 bytes, then arms an 8N1 receiver on `rx` and collects a 4-byte response into a 32-bit word.
- Sits in the tester/host FPGA opposite the PUF device, or in a loopback bench harness.
- Includes its own bit-timing, TX shifter, RX synchronizer/sampler and timeout.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- TIMEOUT_CLKS, 1000000, maximum idle clocks allowed in WAIT_RESP before a start bit is detected.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a transaction; sampled only when busy=0
- challenge  input  16  challenge word; latched on accepted start
- busy  output  1  high from the cycle after an accepted start until the result/abort cycle
- tx  output  1  UART serial out, idle high
- rx  input  1  UART serial in, asynchronous, idle high
- response  output  32  last successfully received response; held until the next resp_valid
- resp_valid  output  1  one-cycle pulse, response updated
- timeout  output  1  one-cycle pulse, transaction aborted for no response
- frame_err  output  1  one-cycle pulse, transaction aborted on a bad stop bit

Behaviour:
- Reset, asynchronous: tx=1, busy=0, response=0, resp_valid=timeout=frame_err=0, FSM=IDLE, all counters 0. Reset mid-transaction aborts immediately and tx returns high with no glitch low.
- Framing: 8N1, LSB-first bits. Challenge byte order is challenge[7:0] then challenge[15:8]. Response byte order is byte0→response[7:0] … byte3→response[31:24].
- FSM states: IDLE, TX_BYTE, RX_WAIT, RX_BYTE, FINISH.
- IDLE:
  - start=1 latches challenge.
  - Next cycle: busy=1, tx=0 (start bit), state TX_BYTE with byte index 0.
  - start while busy=1 is ignored.
- TX_BYTE:
  - Each bit drives tx for exactly CLKS_PER_BIT cycles: start, d0..d7, stop(1).
  - Byte 1 start bit immediately follows byte 0 stop bit (no gap). Frame = 20 bits = 20·CLKS_PER_BIT cycles.
  - After byte 1 stop bit completes, go to RX_WAIT with the timeout counter cleared.
- RX input path: 2-flop synchronizer. rx is ignored in IDLE and TX_BYTE, so no buffering of early bytes.
- RX_WAIT:
  - The timeout counter increments each cycle.
  - Synchronized rx=0 → RX_BYTE.
  - Counter reaching TIMEOUT_CLKS → timeout pulse, busy=0, IDLE; response unchanged.
- RX_BYTE:
  - Wait CLKS_PER_BIT/2 (integer division), recheck rx. If rx=1, it is a false start: return to RX_WAIT without clearing the timeout counter.
  - Otherwise sample d0..d7 and the stop bit at CLKS_PER_BIT intervals.
  - Stop sample 0 → frame_err pulse, busy=0, IDLE; response unchanged.
  - Stop sample 1 → store the byte into the shadow register. If byte index<3, increment the index, clear the timeout counter and go to RX_WAIT; otherwise go to FINISH.
- FINISH (one cycle): copy shadow to response, resp_valid=1, busy=0 in the same cycle, then IDLE. A new start can be accepted on the following cycle.
- Simultaneous events: timeout expiry on the same cycle rx falls → timeout wins. Pulses are mutually exclusive.
- Latency, no-delay responder: busy duration = 20·CLKS_PER_BIT + responder turnaround + 40·CLKS_PER_BIT + a few cycles of sync/mid-bit offset.

Test Plan:
Setup for all scenarios: CLKS_PER_BIT=4, TIMEOUT_CLKS=200.
1. Reset, no stimulus → tx=1, busy=0, response=0; no pulses for 500 cycles.
2. start with challenge=16'hA53C → the bench decodes 2 bytes 0x3C, 0xA5 with every bit exactly 4 cycles wide, total frame 80 cycles, and tx=1 afterwards.
3. After the challenge, the bench model drives bytes 0xEF, 0xBE, 0xAD, 0xDE with 8-bit-time gaps → exactly one resp_valid pulse, response=32'hDEADBEEF, busy falls the same cycle.
4. After the challenge, no rx activity → timeout pulse exactly 200 cycles after RX_WAIT entry; response retains the prior value 32'hDEADBEEF.
5. Byte 2 of the response sent with stop bit 0 → frame_err pulse, no resp_valid, busy=0. A following start with 16'h0001 then completes normally with response 32'h12345678.
6. Two extra cases:
   - A 1-cycle rx low glitch in RX_WAIT is rejected as a false start, and the transaction still completes.
   - Asserting rst during challenge bit d3 → tx=1 and busy=0 immediately; no pulses occur.

Source files
------------

// File: rtl/puf_host_ctrl.sv
// Host-side PUF challenge/response link master.
// Sends a 16-bit challenge as two 8N1 bytes, then collects a 4-byte response.
module puf_host_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] challenge,
    output logic        busy,
    output logic        tx,
    input  logic        rx,
    output logic [31:0] response,
    output logic        resp_valid,
    output logic        timeout,
    output logic        frame_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_BYTE = 3'd1;
    localparam logic [2:0] RX_WAIT = 3'd2;
    localparam logic [2:0] RX_BYTE = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    logic [2:0]    state;
    logic [15:0]   chal;
    logic [1:0]    byte_idx;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] clk_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    rx_byte;
    logic [31:0]   shadow;
    logic          rx_meta;
    logic          rx_sync;
    logic [7:0]    tx_byte;

    assign tx_byte = byte_idx[0] ? chal[15:8] : chal[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            chal       <= '0;
            byte_idx   <= '0;
            bit_cnt    <= '0;
            clk_cnt    <= '0;
            to_cnt     <= '0;
            rx_byte    <= '0;
            shadow     <= '0;
            response   <= '0;
            busy       <= 1'b0;
            tx         <= 1'b1;
            resp_valid <= 1'b0;
            timeout    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            timeout    <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        chal     <= challenge;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        clk_cnt  <= '0;
                        state    <= TX_BYTE;
                    end
                end
                // bit_cnt: 0 = start, 1..8 = data, 9 = stop
                TX_BYTE: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (byte_idx[0]) begin
                                byte_idx <= '0;
                                to_cnt   <= '0;
                                state    <= RX_WAIT;
                            end else begin
                                byte_idx <= 2'd1;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx <= (bit_cnt == 4'd8) ? 1'b1
                                                    : tx_byte[bit_cnt[2:0]];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (!rx_sync) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= RX_BYTE;
                    end
                end
                RX_BYTE: begin
                    if (bit_cnt == 4'd0) begin
                        if (clk_cnt == HALF_LAST) begin
                            clk_cnt <= '0;
                            if (rx_sync) begin
                                state <= RX_WAIT;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end else if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt != 4'd9) begin
                            rx_byte <= {rx_sync, rx_byte[7:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (!rx_sync) begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            shadow[{byte_idx, 3'b000} +: 8] <= rx_byte;
                            if (byte_idx != 2'd3) begin
                                byte_idx <= byte_idx + 2'd1;
                                to_cnt   <= '0;
                                state    <= RX_WAIT;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    response   <= shadow;
                    resp_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_host_ctrl.sv
// Randomized bench for puf_host_ctrl: decodes tx frames, plays a UART
// responder on rx and compares results against a transaction-level model.
module tb_puf_host_ctrl;

    localparam int CPB = 4;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] challenge = '0;
    logic        rx = 1'b1;
    logic        busy;
    logic        tx;
    logic [31:0] response;
    logic        resp_valid;
    logic        timeout;
    logic        frame_err;

    puf_host_ctrl #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .challenge (challenge),
        .busy      (busy),
        .tx        (tx),
        .rx        (rx),
        .response  (response),
        .resp_valid(resp_valid),
        .timeout   (timeout),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] model_resp = '0;

    // pulse monitor: totals plus details of the most recent pulse
    int   rv_n = 0, to_n = 0, fe_n = 0, multi_n = 0;
    int   last_kind = 0, last_cyc = 0;
    logic last_busy = 1'b0, last_prev = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        prev_busy <= busy;
        if (resp_valid | timeout | frame_err) begin
            last_cyc  <= cyc;
            last_busy <= busy;
            last_prev <= prev_busy;
            last_kind <= resp_valid ? 1 : (timeout ? 2 : 3);
            if (resp_valid) rv_n <= rv_n + 1;
            if (timeout) to_n <= to_n + 1;
            if (frame_err) fe_n <= fe_n + 1;
            if (int'(resp_valid) + int'(timeout) + int'(frame_err) > 1)
                multi_n <= multi_n + 1;
        end
    end

    function automatic int pulses();
        return rv_n + to_n + fe_n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx = b[j];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // nbytes=0 -> silent responder; err_idx>=0 -> that byte has a bad stop
    task automatic run_txn(input logic [15:0] ch, input logic [31:0] word,
                           input int nbytes, input int err_idx,
                           input bit glitch, input int turn, input int gap);
        logic       s[80];
        logic [7:0] b0, b1;
        logic [3:0] frm;
        int base, k, bad, exp_kind, t0;
        exp_kind = (nbytes == 0) ? 2 : ((err_idx >= 0) ? 3 : 1);
        base = pulses();
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        challenge = 16'($urandom);
        k = 0;
        while (tx !== 1'b0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (tx !== 1'b0) begin
            chk("tx_start", 32'(tx), 32'd0);
            return;
        end
        t0 = cyc;
        chk("busy_on", 32'(busy), 32'd1);
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk);
            s[i] = tx;
        end
        bad = 0;
        for (int j = 0; j < 20; j++)
            for (int m = 1; m < 4; m++)
                if (s[4*j+m] !== s[4*j]) bad++;
        for (int j = 0; j < 8; j++) begin
            b0[j] = s[4*(j+1)];
            b1[j] = s[4*(j+11)];
        end
        frm = {s[0], s[36], s[40], s[76]};
        chk("tx_width", 32'(bad), 32'd0);
        chk("tx_byte0", 32'(b0), 32'(ch[7:0]));
        chk("tx_byte1", 32'(b1), 32'(ch[15:8]));
        chk("tx_frame", 32'(frm), 32'b0101);
        @(negedge clk);
        chk("tx_idle", 32'(tx), 32'd1);
        repeat (turn) @(negedge clk);
        if (glitch) begin
            rx = 1'b0;
            @(negedge clk);
            rx = 1'b1;
            repeat (10) @(negedge clk);
        end
        for (int i = 0; i < nbytes; i++) begin
            send_byte(word[8*i +: 8], i != err_idx);
            if (i == err_idx) break;
            if (i < nbytes - 1) repeat (gap) @(negedge clk);
        end
        k = 0;
        while (pulses() == base && k < TO + 100) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        chk("n_pulse", 32'(pulses() - base), 32'd1);
        chk("kind", 32'(last_kind), 32'(exp_kind));
        chk("busy_drop", 32'({last_prev, last_busy}), 32'b10);
        if (exp_kind == 2)
            chk("to_lat", 32'(last_cyc - t0), 32'(80 + TO));
        if (exp_kind == 1) model_resp = word;
        chk("response", response, model_resp);
        chk("exclusive", 32'(multi_n), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base, k;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp", response, 32'd0);
        repeat (500) @(negedge clk);
        chk("idle_pulses", 32'(pulses()), 32'd0);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        run_txn(16'hA53C, 32'hDEADBEEF, 4, -1, 1'b0, 5, 8 * CPB);
        run_txn(16'($urandom), 32'h0, 0, -1, 1'b0, 0, 0);
        run_txn(16'($urandom), $urandom, 4, 2, 1'b0, 7, 8 * CPB);
        run_txn(16'h0001, 32'h12345678, 4, -1, 1'b0, 3, 8 * CPB);
        run_txn(16'($urandom), $urandom, 4, -1, 1'b1, 6, 8 * CPB);
        for (int i = 0; i < 4; i++)
            run_txn(16'($urandom), $urandom, 4, -1, 1'b0,
                    int'($urandom_range(0, 40)),
                    int'($urandom_range(8, 40)));

        // abort during challenge bit d3
        @(negedge clk);
        challenge = 16'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        repeat (17) @(negedge clk);
        base = pulses();
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_resp = '0;
        repeat (300) @(negedge clk);
        chk("abort_pulses", 32'(pulses() - base), 32'd0);
        chk("abort_resp", response, model_resp);
        chk("abort_idle_tx", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
